// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- clocked execute-stage ALU with a valid/ready handshake.
//
// Base RV32I ops finish one cycle after acceptance. RV32M multiply/divide
// (when M_EXT=1) iterate one bit per cycle through CALC, then get their sign
// and half/quotient/remainder selection applied in FIX.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      synchronous abort of any in-flight op (result is kept)
//   in_valid   operation request from decode
//   in_ready   block can accept (state IDLE)
//   op         {m, alt, funct3}; m selects RV32M, alt selects SUB/SRA
//   A, B       operands rs1 and rs2/immediate
//   out_valid  result available to writeback
//   out_ready  writeback takes the result
//   result     registered result
//   illegal    qualifies result: op not supported in this configuration
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int XLEN  = 32,
  parameter int M_EXT = 1,
  parameter int SHW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;

  logic              accept;
  logic              is_m;
  logic              md_op;

  // Base ALU
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_res;

  // Operand preparation for mul/div at accept time
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;

  // Iterative datapath
  logic [2:0]        md_f3;
  logic              neg_a_q;
  logic              neg_b_q;
  logic              b_zero_q;
  logic [XLEN-1:0]   mdr;      // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0]   acc;      // product high half (mul) or partial remainder (div)
  logic [XLEN-1:0]   lo;       // multiplier/product low half (mul) or dividend/quotient (div)
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     sh_rem;
  logic [XLEN:0]     sub_diff;

  // Final fix-up
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   md_res;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // A request coinciding with flush is dropped, not accepted.
  assign accept    = in_valid && in_ready && !flush;
  assign is_m      = op[4];
  assign md_op     = is_m && (M_EXT != 0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every register in the
    // design samples the values present before the clock edge.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: the default is assigned before the case so no path leaves
    // state_nxt unassigned, which would infer a latch.
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = md_op ? CALC : DONE;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Base (single-cycle) ALU, evaluated on the operands at accept time
  // ---------------------------------------------------------------------------
  assign shamt = B[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (op[2:0])
      3'd0: base_res = op[3] ? (A - B) : (A + B);
      3'd1: base_res = A << shamt;
      3'd2: base_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      3'd3: base_res = {{(XLEN-1){1'b0}}, (A < B)};
      3'd4: base_res = A ^ B;
      3'd5: base_res = op[3] ? $unsigned($signed(A) >>> shamt) : (A >> shamt);
      3'd6: base_res = A | B;
      3'd7: base_res = A & B;
      default: base_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Mul/div operand magnitudes. MUL (funct3 0) is treated as unsigned since
  // its low half does not depend on signedness.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_sgn = (op[2:0] == 3'd1) || (op[2:0] == 3'd2) ||
            (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
    b_sgn = (op[2:0] == 3'd1) || (op[2:0] == 3'd4) || (op[2:0] == 3'd6);
    a_neg = a_sgn && A[XLEN-1];
    b_neg = b_sgn && B[XLEN-1];
    // -2^(XLEN-1) maps onto itself, which is the correct unsigned magnitude.
    a_mag = a_neg ? (~A + 1'b1) : A;
    b_mag = b_neg ? (~B + 1'b1) : B;
  end

  // ---------------------------------------------------------------------------
  // One iteration of shift-add multiply and restoring divide
  // ---------------------------------------------------------------------------
  always_comb begin
    add_sum  = {1'b0, acc} + (lo[0] ? {1'b0, mdr} : {(XLEN+1){1'b0}});
    sh_rem   = {acc, lo[XLEN-1]};
    // Bit XLEN set means the trial subtraction went negative: restore.
    sub_diff = sh_rem - {1'b0, mdr};
  end

  // NOTE: these datapath registers carry no reset; every op that reads them
  // loads them on its accept cycle first, and the FSM reset alone guarantees
  // no stale value reaches result.
  always_ff @(posedge clk) begin
    if (accept && md_op) begin
      md_f3    <= op[2:0];
      neg_a_q  <= a_neg;
      neg_b_q  <= b_neg;
      b_zero_q <= (B == '0);
      acc      <= '0;
      if (op[2]) begin
        mdr <= b_mag;
        lo  <= a_mag;
      end else begin
        mdr <= a_mag;
        lo  <= b_mag;
      end
    end else if (state == CALC) begin
      if (md_f3[2]) begin
        acc <= sub_diff[XLEN] ? sh_rem[XLEN-1:0] : sub_diff[XLEN-1:0];
        lo  <= {lo[XLEN-2:0], ~sub_diff[XLEN]};
      end else begin
        acc <= add_sum[XLEN:1];
        lo  <= {add_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result selection. Signed overflow (-2^(XLEN-1) / -1)
  // falls out naturally: quotient magnitude 2^(XLEN-1) negates to itself and
  // the remainder is 0. Divide by zero leaves remainder = |A|, which the
  // dividend sign turns back into A; only the quotient needs forcing.
  // ---------------------------------------------------------------------------
  always_comb begin
    prod     = {acc, lo};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
    quot_fix = b_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? (~lo + 1'b1) : lo);
    rem_fix  = neg_a_q ? (~acc + 1'b1) : acc;
    md_res   = '0;
    case (md_f3)
      3'd0:              md_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:  md_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:        md_res = quot_fix;
      3'd6, 3'd7:        md_res = rem_fix;
      default:           md_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result, illegal flag and iteration counter. Flush freezes them so the last
  // delivered result survives an abort.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      illegal <= 1'b0;
      cnt     <= '0;
    end else if (!flush) begin
      if (accept) begin
        illegal <= is_m && !md_op;
        cnt     <= CNT_LOAD;
        if (!is_m) begin
          result <= base_res;
        end else if (!md_op) begin
          result <= '0;
        end
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        result <= md_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq.
// Main instance: XLEN=32, M_EXT=1. Second instance: M_EXT=0.
// Expected results are pushed to a scoreboard queue when an op is driven and
// popped by a monitor when the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int XLEN   = 32;
  localparam int LAT_B  = 1;
  localparam int LAT_MD = XLEN + 2;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b01000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b01101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  logic            in_valid_x;
  logic            in_ready_x;
  logic [4:0]      op_x;
  logic [XLEN-1:0] a_x;
  logic [XLEN-1:0] b_x;
  logic            out_valid_x;
  logic [XLEN-1:0] result_x;
  logic            illegal_x;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN), .M_EXT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  alu_seq #(.XLEN(XLEN), .M_EXT(0)) dut_nom (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .in_valid  (in_valid_x),
    .in_ready  (in_ready_x),
    .op        (op_x),
    .A         (a_x),
    .B         (b_x),
    .out_valid (out_valid_x),
    .out_ready (1'b1),
    .result    (result_x),
    .illegal   (illegal_x)
  );

  typedef struct {
    string           tag;
    logic [XLEN-1:0] res;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every handed-over result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_res"}, 64'(result), 64'(mon_e.res));
        check({mon_e.tag, "_ill"}, 64'(illegal), 64'(mon_e.ill));
      end
    end
  end

  // Drive one op; when want_out is set, push its expectation and check latency.
  task automatic issue(input string tag, input logic [4:0] o,
                       input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] exp, input int exp_lat,
                       input bit want_out);
    int n;
    int lat;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
      return;
    end
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    if (want_out) begin
      e.tag = tag;
      e.res = exp;
      e.ill = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!want_out) return;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    op         = '0;
    a          = '0;
    b          = '0;
    in_valid_x = 1'b0;
    op_x       = '0;
    a_x        = '0;
    b_x        = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_nom_valid", 64'(out_valid_x), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Base ops
    issue("sub",      OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, LAT_B, 1);
    issue("sra",      OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, LAT_B, 1);
    issue("srl",      OP_SRL,  32'h80000000, 32'h00000024, 32'h08000000, LAT_B, 1);
    issue("slt",      OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        LAT_B, 1);
    issue("sltu",     OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        LAT_B, 1);
    issue("slt_pos",  OP_SLT,  32'd5,        32'hFFFFFFFF, 32'd0,        LAT_B, 1);
    issue("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'd2,        32'd1,        LAT_B, 1);
    issue("sll31",    OP_SLL,  32'd1,        32'h0000003F, 32'h80000000, LAT_B, 1);
    issue("sll0",     OP_SLL,  32'h00001234, 32'h00000020, 32'h00001234, LAT_B, 1);
    issue("xor_alt",  OP_XOR | 5'b01000, 32'd3, 32'd5,     32'd6,        LAT_B, 1);
    issue("or",       OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, LAT_B, 1);
    issue("and",      OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, LAT_B, 1);

    // Multiply
    issue("mulh_m1",  OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_MD, 1);
    issue("mulhu_m1", OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MD, 1);
    issue("mul",      OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, LAT_MD, 1);
    issue("mulhsu",   OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_MD, 1);
    issue("mulh_min", OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_MD, 1);

    // Divide, including corners
    issue("div_by0",   OP_DIV,  32'd7,        32'd0,        32'hFFFFFFFF, LAT_MD, 1);
    issue("rem_by0",   OP_REM,  32'd7,        32'd0,        32'd7,        LAT_MD, 1);
    issue("divn_by0",  OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, LAT_MD, 1);
    issue("remn_by0",  OP_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, LAT_MD, 1);
    issue("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_MD, 1);
    issue("rem_ovf",   OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_MD, 1);
    issue("rem_neg",   OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_MD, 1);
    issue("div_neg",   OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_MD, 1);
    issue("divu",      OP_DIVU, 32'd100,      32'd7,        32'd14,       LAT_MD, 1);
    issue("remu",      OP_REMU, 32'd100,      32'd7,        32'd2,        LAT_MD, 1);
    issue("divu_by0",  OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_MD, 1);

    // Reset in the middle of a divide
    drain();
    issue("div_abort", OP_DIV, 32'd100, 32'd7, 32'd0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("add_after_rst", OP_ADD, 32'd3, 32'd4, 32'd7, LAT_B, 1);

    // Backpressure: result held, no new accept
    drain();
    out_ready = 1'b0;
    issue("bp", OP_XOR, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, LAT_B, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result", 64'(result), 64'hAAAAAAAA);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Flush during CALC
    drain();
    issue("flush_mul", OP_MUL, 32'd3, 32'd5, 32'd0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_output", 64'(seen), 64'd0);
    check("flush_result_kept", 64'(result), 64'hAAAAAAAA);

    // Request coinciding with flush is dropped
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = OP_ADD;
    a        = 32'd1;
    b        = 32'd1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flushacc_out_valid", 64'(out_valid), 64'd0);
    check("flushacc_in_ready", 64'(in_ready), 64'd1);
    check("flushacc_result", 64'(result), 64'hAAAAAAAA);
    issue("add_post_flush", OP_ADD, 32'd10, 32'd20, 32'd30, LAT_B, 1);

    // M_EXT=0 instance: mul/div illegal, base ops legal
    @(negedge clk);
    in_valid_x = 1'b1;
    op_x       = OP_MUL;
    a_x        = 32'd3;
    b_x        = 32'd4;
    @(posedge clk);
    #1;
    in_valid_x = 1'b0;
    check("nom_mul_valid", 64'(out_valid_x), 64'd1);
    check("nom_mul_result", 64'(result_x), 64'd0);
    check("nom_mul_illegal", 64'(illegal_x), 64'd1);
    repeat (2) @(negedge clk);
    in_valid_x = 1'b1;
    op_x       = OP_ADD;
    @(posedge clk);
    #1;
    in_valid_x = 1'b0;
    check("nom_add_valid", 64'(out_valid_x), 64'd1);
    check("nom_add_result", 64'(result_x), 64'd7);
    check("nom_add_illegal", 64'(illegal_x), 64'd0);

    drain();
    repeat (3) @(negedge clk);
    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational RV32I ALU.
- Adds a registered valid/ready interface, RV32M multiply/divide (iterative, one bit per cycle), explicit SUB and SRA select, and a pipeline flush.
- Sits in the execute stage. The decode stage drives the operation and operands. Writeback consumes the result.

Parameters:
- XLEN, 32, operand/result width; power of two, 8..64.
- M_EXT, 1, 1 enables mul/div ops; 0 makes them illegal.
- SHW, $clog2(XLEN), shift-amount width taken from B[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept (state IDLE).
- op  in  5  {m, alt, funct3}; m=1 selects RV32M funct3, alt selects SUB/SRA.
- A  in  XLEN  operand rs1.
- B  in  XLEN  operand rs2/immediate.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- illegal  out  1  qualifies result; op not supported.

Behaviour:
- Reset: clk rising edge with rst_n=0 forces state=IDLE, out_valid=0, result=0, illegal=0, counter=0. Reset overrides flush and every handshake.
- Flush: state->IDLE, out_valid=0 next cycle, partial mul/div state discarded, result unchanged. An in_valid in the same cycle as flush is not accepted.
- Acceptance: in_valid & in_ready on a rising edge latches op, A, B. in_ready = (state==IDLE) only, so no accept in the cycle a result is released.
- States: IDLE, CALC, FIX, DONE.
  - IDLE->DONE for base ops.
  - IDLE->CALC for mul/div with M_EXT=1.
  - CALC->FIX when counter reaches 0.
  - FIX->DONE.
  - DONE->IDLE when out_ready=1.
- Base ops (m=0), latency 1 (accept at T, out_valid at T+1):
  - funct3 0: ADD, or SUB when alt=1.
  - 1: SLL.
  - 2: SLT signed.
  - 3: SLTU.
  - 4: XOR.
  - 5: SRL, or SRA when alt=1; the fill bit is A[XLEN-1] only when alt=1.
  - 6: OR.
  - 7: AND.
  - alt is ignored for funct3 other than 0 and 5.
  - SLT/SLTU produce 1 or 0, zero-extended.
  - Shift uses B[SHW-1:0] only; a shift of 0 returns A.
  - Add/sub wrap modulo 2^XLEN with no flag.
- Mul/div (m=1, M_EXT=1), latency XLEN+2 (accept T, out_valid at T+XLEN+2):
  - Accept cycle registers |A|, |B| per signedness and the result sign.
  - CALC runs exactly XLEN cycles; counter loads XLEN-1 and decrements.
  - MUL: shift-add into a 2*XLEN-bit product.
  - DIV: restoring shift-subtract.
  - FIX applies sign negation and selects the low or high half / quotient / remainder.
  - funct3 0 MUL: low half.
  - 1 MULH: signed×signed, high half.
  - 2 MULHSU: signed A × unsigned B, high half.
  - 3 MULHU: high half.
  - 4 DIV, 5 DIVU: quotient.
  - 6 REM, 7 REMU: remainder.
  - Remainder takes the sign of the dividend.
- Divide corner cases (full XLEN+2 latency still applies):
  - Divide by zero: quotient = all ones; remainder = A.
  - Signed overflow (A = -2^(XLEN-1), B = -1): DIV = A; REM = 0.
- M_EXT=0 with m=1: latency 1, result=0, illegal=1.
- illegal is 0 for all legal ops and is valid only while out_valid=1.
- Output hold: result and illegal remain stable while out_valid=1 & out_ready=0, for any number of cycles.
- Back-to-back: with out_ready tied 1, base-op throughput is one op per 2 cycles.

Test Plan:
- Reset mid-operation: rst_n=0 during CALC of DIV -> next cycle in_ready=1, out_valid=0, result=0; a following ADD 3+4 returns 7 at T+1.
- Base ops, XLEN=32:
  - SUB 5-7 -> 0xFFFFFFFE.
  - SRA 0x80000000 by B=0x24 (shamt 4) -> 0xF8000000.
  - SRL same -> 0x08000000.
  - SLT 0xFFFFFFFF<1 -> 1.
  - SLTU same -> 0.
  - All results at T+1.
- Multiply:
  - MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000.
  - MULHU same -> 0xFFFFFFFE.
  - MUL 0x12345678×0x10 -> 0x23456780.
  - out_valid exactly 34 cycles after accept.
- Divide corners:
  - DIV 7/0 -> 0xFFFFFFFF.
  - REM 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same -> 0.
  - REM -7/2 -> 0xFFFFFFFF.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles after DONE -> result stable, in_ready=0.
  - Flush asserted during CALC -> out_valid stays 0 and in_ready=1 next cycle.
- M_EXT=0 instance: MUL 3×4 -> result=0, illegal=1 at T+1.
